spram_port_ctrl: RTL

Initiator-side controller for the single-port RAM wrapper. On reset or flush it sweeps every word to a fixed value, which cache tag and valid arrays use for invalidation. After the sweep it accepts one read or write request per cycle on a valid/ready port and drives the RAM's `en`/`we`/`addr`/`din`. It returns read data with a response-valid strobe aligned to the RAM's read latency. It sits between cache control logic and one RAM instance.

---
 rtl/spram_port_ctrl.sv | 107 ++++++++++
 1 files changed

// File: rtl/spram_port_ctrl.sv
// Initiator-side controller for one single-port RAM: sweeps every word to INIT_VALUE after
// reset or flush, then forwards one valid/ready request per cycle and aligns read responses.
module spram_port_ctrl #(
  parameter int unsigned            DATA_WIDTH = 32,
  parameter int unsigned            DEPTH      = 128,
  parameter int unsigned            LATENCY    = 1,
  parameter logic [DATA_WIDTH-1:0]  INIT_VALUE = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_we,
  input  logic [$clog2(DEPTH)-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]      req_wdata,
  output logic                       resp_valid,
  output logic [DATA_WIDTH-1:0]      resp_rdata,
  output logic                       init_done,
  output logic                       ram_en,
  output logic                       ram_we,
  output logic [$clog2(DEPTH)-1:0]   ram_addr,
  output logic [DATA_WIDTH-1:0]      ram_din,
  input  logic [DATA_WIDTH-1:0]      ram_dout
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e             state_q, state_d;
  logic [AW-1:0]      cnt_q, cnt_d;
  logic [LATENCY-1:0] pend_q, pend_d;
  logic               fire;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_ready = 1'b0;
    init_done = 1'b0;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = cnt_q;
    ram_din   = INIT_VALUE;

    unique case (state_q)
      StInit: begin
        ram_en = 1'b1;
        ram_we = 1'b1;
        // A flush mid-sweep restarts from address 0, even on the last word.
        if (flush) begin
          cnt_d = '0;
        end else if (cnt_q == LastAddr) begin
          state_d = StRun;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRun: begin
        req_ready = 1'b1;
        init_done = 1'b1;
        ram_en    = req_valid;
        ram_we    = req_valid & req_we;
        ram_addr  = req_addr;
        ram_din   = req_wdata;
        if (flush) begin
          state_d = StInit;
          cnt_d   = '0;
        end
      end
      default: state_d = StInit;
    endcase

    if (rst) begin
      req_ready = 1'b0;
      init_done = 1'b0;
      ram_en    = 1'b0;
      ram_we    = 1'b0;
    end
  end

  assign fire = req_valid & req_ready;

  // One bit per read in flight; the top bit lines up with the RAM's output data.
  always_comb begin
    pend_d    = pend_q << 1;
    pend_d[0] = fire & ~req_we;
  end

  assign resp_valid = ~rst & pend_q[LATENCY-1];
  assign resp_rdata = ram_dout;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StInit;
      cnt_q   <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

endmodule
